// File: rtl/ts_pkt_rr_arbiter_if.sv
// Bus bundle between TS sources, the packet arbiter and the downstream checkers.
interface ts_pkt_rr_arbiter_if #(
   parameter int unsigned N = 4
);
   logic [N-1:0]    port_en;
   logic [N-1:0]    req;
   logic [N-1:0]    gnt;
   logic [2:0]      gnt_id;
   logic [N*32-1:0] ts_din;
   logic [N-1:0]    ts_din_en;
   logic [31:0]     ts_dout;
   logic            ts_dout_en;
   logic            sync_err;
   logic            len_err;
   logic            timeout_err;

   // Arbiter side
   modport slave (
      input  port_en, req, ts_din, ts_din_en,
      output gnt, gnt_id, ts_dout, ts_dout_en, sync_err, len_err, timeout_err
   );

   // Source / environment side
   modport master (
      output port_en, req, ts_din, ts_din_en,
      input  gnt, gnt_id, ts_dout, ts_dout_en, sync_err, len_err, timeout_err
   );
endinterface

// File: rtl/ts_pkt_rr_arbiter.sv
// Round-robin TS packet arbiter: grants whole 47-word packets from N sources onto
// one registered word stream, checking sync byte, length, start timeout and gap.
module ts_pkt_rr_arbiter #(
   parameter int unsigned N          = 4,
   parameter int unsigned PKT_WORDS  = 47,
   parameter int unsigned TIMEOUT    = 16,
   parameter int unsigned GAP_CYCLES = 1
) (
   input logic                clk,
   input logic                rst,
   ts_pkt_rr_arbiter_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(PKT_WORDS + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, WAIT, XFER, DROP, GAP} state_t;

   state_t           state;
   logic [2:0]       ptr;
   logic [CNT_W-1:0] cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [GAP_W-1:0] gap_cnt;

   logic [N-1:0]     cand;
   logic [N-1:0]     cand_sh;
   logic             found;
   logic [2:0]       win;
   logic             cur_en;
   logic [31:0]      cur_word;
   logic [N-1:0]     onehot_base;

   assign cand        = bus.req & bus.port_en;
   assign onehot_base = {{(N-1){1'b0}}, 1'b1};

   // Round-robin search starting one past the last winner, wrapping modulo N.
   always_comb begin
      int unsigned idx;
      found   = 1'b0;
      win     = '0;
      idx     = 0;
      cand_sh = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         idx     = (32'(ptr) + i) % N;
         cand_sh = cand >> idx;
         if (!found && cand_sh[0]) begin
            found = 1'b1;
            win   = 3'(idx);
         end
      end
   end

   // Mux out the granted source's enable and word; other sources are ignored.
   always_comb begin
      cur_en   = 1'b0;
      cur_word = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (3'(k) == bus.gnt_id) begin
            cur_en   = bus.ts_din_en[k];
            cur_word = bus.ts_din[32*k +: 32];
         end
      end
   end

   // Packet FSM with registered grant, datapath and error pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         ptr             <= 3'(N - 1);
         cnt             <= '0;
         tmo_cnt         <= '0;
         gap_cnt         <= '0;
         bus.gnt         <= '0;
         bus.gnt_id      <= '0;
         bus.ts_dout     <= '0;
         bus.ts_dout_en  <= 1'b0;
         bus.sync_err    <= 1'b0;
         bus.len_err     <= 1'b0;
         bus.timeout_err <= 1'b0;
      end else begin
         bus.ts_dout_en  <= 1'b0;
         bus.sync_err    <= 1'b0;
         bus.len_err     <= 1'b0;
         bus.timeout_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (found) begin
                  bus.gnt    <= onehot_base << win;
                  bus.gnt_id <= win;
                  ptr        <= win;
                  tmo_cnt    <= '0;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               if (cur_en) begin
                  if (cur_word[31:24] == 8'h47) begin
                     bus.ts_dout    <= cur_word;
                     bus.ts_dout_en <= 1'b1;
                     cnt            <= CNT_W'(1);
                     state          <= XFER;
                  end else begin
                     bus.sync_err <= 1'b1;
                     state        <= DROP;
                  end
               end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                  bus.timeout_err <= 1'b1;
                  bus.gnt         <= '0;
                  gap_cnt         <= '0;
                  state           <= GAP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            XFER: begin
               if (cnt == CNT_W'(PKT_WORDS)) begin
                  // Packet complete; a word still arriving now is overlong and dropped.
                  bus.len_err <= cur_en;
                  bus.gnt     <= '0;
                  gap_cnt     <= '0;
                  state       <= GAP;
               end else if (cur_en) begin
                  bus.ts_dout    <= cur_word;
                  bus.ts_dout_en <= 1'b1;
                  cnt            <= cnt + 1'b1;
               end else begin
                  bus.len_err <= 1'b1;
                  bus.gnt     <= '0;
                  gap_cnt     <= '0;
                  state       <= GAP;
               end
            end
            DROP: begin
               if (!cur_en) begin
                  bus.gnt <= '0;
                  gap_cnt <= '0;
                  state   <= GAP;
               end
            end
            GAP: begin
               // The last gap cycle doubles as an arbitration cycle.
               if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                  if (found) begin
                     bus.gnt    <= onehot_base << win;
                     bus.gnt_id <= win;
                     ptr        <= win;
                     tmo_cnt    <= '0;
                     state      <= WAIT;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ts_pkt_rr_arbiter.sv
// Directed bench for ts_pkt_rr_arbiter with hand-computed expectations.
module tb_ts_pkt_rr_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   ts_pkt_rr_arbiter_if #(.N(4)) bus ();

   ts_pkt_rr_arbiter #(
      .N(4), .PKT_WORDS(47), .TIMEOUT(16), .GAP_CYCLES(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word(input int src, input int i, input logic [31:0] first);
      logic [3:0] s;
      logic [7:0] n;
      s = 4'(src);
      n = 8'(i);
      return (i == 0) ? first : {4'hA, s, 16'h0000, n};
   endfunction

   // Wait (bounded) for a grant, then check it went to src.
   task automatic wait_gnt(input int src, input int max);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (bus.gnt == 4'b0 && k < max);
      chk("gnt_onehot", bus.gnt, 32'(4'b0001 << src));
      chk("gnt_id", bus.gnt_id, 32'(src));
   endtask

   // Drive an n-word burst from src and check forwarding, grant and error pulses.
   task automatic send(input int src, input int n, input logic [31:0] first);
      logic        ok;
      logic [31:0] w;
      logic [3:0]  oh;
      int          last;
      ok = (first[31:24] == 8'h47);
      oh = 4'b0001 << src;
      for (int i = 0; i < n; i++) begin
         w = word(src, i, first);
         bus.ts_din_en = 4'b0;
         bus.ts_din_en[src] = 1'b1;
         bus.ts_din[src*32 +: 32] = w;
         step();
         if (ok && i < 47) begin
            chk("dout_en", bus.ts_dout_en, 1);
            chk("dout", bus.ts_dout, w);
         end else begin
            chk("dout_en_idle", bus.ts_dout_en, 0);
         end
         chk("gnt_during", bus.gnt, (i < 47) ? 32'(oh) : 32'h0);
         chk("sync_err", bus.sync_err, 32'(i == 0 && !ok));
         chk("len_err", bus.len_err, 32'(ok && i == 47));
      end
      bus.ts_din_en = 4'b0;
      step();
      chk("end_gnt", bus.gnt, 0);
      chk("end_dout_en", bus.ts_dout_en, 0);
      chk("end_len_err", bus.len_err, 32'(ok && n < 47));
      chk("end_sync_err", bus.sync_err, 0);
      if (ok) begin
         last = (n < 47) ? n - 1 : 46;
         chk("dout_hold", bus.ts_dout, word(src, last, first));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.port_en = 4'b0;
      bus.req = 4'b0;
      bus.ts_din = '0;
      bus.ts_din_en = 4'b0;
      step();
      step();
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_gnt_id", bus.gnt_id, 0);
      chk("rst_dout", bus.ts_dout, 0);
      chk("rst_dout_en", bus.ts_dout_en, 0);
      chk("rst_errs", {bus.sync_err, bus.len_err, bus.timeout_err}, 0);
      rst = 1'b0;
      step();
      chk("idle_gnt", bus.gnt, 0);

      // Single source 2, exact-length packet.
      bus.port_en = 4'b1111;
      bus.req = 4'b0100;
      wait_gnt(2, 4);
      bus.req = 4'b0;
      send(2, 47, 32'h47001386);

      // All sources requesting: 0,1,2,3,0 then port_en=1011 gives 1,3,0,1.
      do_reset();
      bus.req = 4'b1111;
      wait_gnt(0, 4); send(0, 47, 32'h47000100);
      wait_gnt(1, 4); send(1, 47, 32'h47000101);
      wait_gnt(2, 4); send(2, 47, 32'h47000102);
      wait_gnt(3, 4); send(3, 47, 32'h47000103);
      wait_gnt(0, 4);
      send(0, 47, 32'h47000200);
      bus.port_en = 4'b1011;
      wait_gnt(1, 4); send(1, 47, 32'h47000201);
      wait_gnt(3, 4); send(3, 47, 32'h47000203);
      wait_gnt(0, 4); send(0, 47, 32'h47000300);
      wait_gnt(1, 4);
      bus.req = 4'b0;
      send(1, 47, 32'h47000301);
      bus.port_en = 4'b1111;

      // Timeout: source 1 granted but silent; en on source 3 must be ignored.
      do_reset();
      bus.req = 4'b0110;
      wait_gnt(1, 4);
      bus.ts_din_en = 4'b1000;
      bus.ts_din[3*32 +: 32] = 32'h47000333;
      for (int k = 1; k <= 16; k++) begin
         step();
         chk("tmo_err", bus.timeout_err, 32'(k == 16));
         chk("tmo_gnt", bus.gnt, (k < 16) ? 32'h2 : 32'h0);
         chk("tmo_dout_en", bus.ts_dout_en, 0);
      end
      bus.ts_din_en = 4'b0;
      wait_gnt(2, 4);
      chk("tmo_err_clear", bus.timeout_err, 0);
      bus.req = 4'b0;
      send(2, 47, 32'h47000402);

      // Bad sync byte, then short and overlong packets from source 0.
      bus.req = 4'b0001;
      wait_gnt(0, 4);
      bus.req = 4'b0;
      send(0, 47, 32'h48001386);
      bus.req = 4'b0001;
      wait_gnt(0, 4);
      bus.req = 4'b0;
      send(0, 30, 32'h47001386);
      bus.req = 4'b0001;
      wait_gnt(0, 4);
      bus.req = 4'b0;
      send(0, 50, 32'h47001387);

      // Reset on word 20 of a packet from source 3.
      bus.req = 4'b1000;
      wait_gnt(3, 4);
      bus.req = 4'b0;
      for (int i = 0; i < 20; i++) begin
         bus.ts_din_en = 4'b1000;
         bus.ts_din[3*32 +: 32] = word(3, i, 32'h47005555);
         step();
         chk("pre_rst_dout", bus.ts_dout, word(3, i, 32'h47005555));
      end
      bus.ts_din[3*32 +: 32] = word(3, 20, 32'h47005555);
      rst = 1'b1;
      #1;
      chk("rst_mid_gnt", bus.gnt, 0);
      chk("rst_mid_dout_en", bus.ts_dout_en, 0);
      bus.ts_din_en = 4'b0;
      step();
      rst = 1'b0;
      bus.req = 4'b1111;
      step();
      chk("post_rst_gnt", bus.gnt, 32'h1);
      chk("post_rst_gnt_id", bus.gnt_id, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ts_pkt_rr_arbiter.md
Name: ts_pkt_rr_arbiter

Overview:
- Round-robin packet arbiter sharing one 32-bit TS word bus among N upstream TS sources.
- Each source presents 188-byte TS packets as 47 contiguous 32-bit words, framed by a per-source enable. The first word carries the sync byte 0x47 in [31:24].
- Grants are issued only at packet boundaries; whole packets are forwarded onto a single ts_dout/ts_dout_en stream feeding the downstream mux/PID/continuity checkers.
- Enforces packet length, sync byte, grant timeout and a minimum inter-packet gap, so downstream word counters (which reset on enable low) re-align on every packet.

Parameters:
- N, 4, number of requesting sources (2..8)
- PKT_WORDS, 47, 32-bit words per TS packet
- TIMEOUT, 16, cycles a granted source may take to start its packet before the grant is revoked
- GAP_CYCLES, 1, minimum idle cycles on ts_dout_en between forwarded packets (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- port_en  in  N  static per-source enable mask; 0 = source never granted
- req  in  N  source k holds a complete packet ready
- gnt  out  N  one-hot grant, registered
- gnt_id  out  3  index of the granted source, valid while gnt != 0
- ts_din  in  N*32  source k word on bits [32k+31:32k]
- ts_din_en  in  N  source k word valid
- ts_dout  out  32  forwarded word
- ts_dout_en  out  1  forwarded word valid
- sync_err  out  1  one-cycle pulse: first word of a granted packet lacks 0x47
- len_err  out  1  one-cycle pulse: packet shorter or longer than PKT_WORDS
- timeout_err  out  1  one-cycle pulse: granted source never started

Behaviour:
- Reset (async assert, release on clk): state IDLE; gnt=0; gnt_id=0; ts_dout=0; ts_dout_en=0; all error pulses 0; word count 0; rr pointer = N-1, so source 0 has first priority.
- FSM states: IDLE, WAIT, XFER, DROP, GAP.
- IDLE: candidates are req & port_en. Pick the first candidate searching from pointer+1, wrapping modulo N.
  - With a candidate: next cycle gnt one-hot, gnt_id set, pointer = winner, go to WAIT.
  - With no candidate: stay in IDLE.
- WAIT: watch ts_din_en[gnt_id]; en on any other source is ignored throughout.
  - Timeout counter runs from 0. If it reaches TIMEOUT with no en: pulse timeout_err, clear gnt, go to GAP.
  - On first en with ts_din[31:24]==8'h47: forward the word, word count = 1, go to XFER.
  - On first en with any other sync byte: pulse sync_err, forward nothing, go to DROP.
- XFER: each cycle with en forwards the word and increments the word count.
  - When the count reaches PKT_WORDS: clear gnt on the following cycle, go to GAP.
  - If en drops before PKT_WORDS words: pulse len_err, clear gnt, go to GAP. Words already forwarded are not retracted.
- DROP: all words of the source are suppressed. When en falls: clear gnt, go to GAP.
- Overlong packets: words arriving after the PKT_WORDS-th word, while gnt is falling, are discarded. len_err pulses once if en is still high on the cycle after the last word.
- GAP: ts_dout_en held low for GAP_CYCLES cycles, then IDLE. New arbitration may occur in the final GAP cycle, so the next gnt rises as the gap ends.
- Datapath timing:
  - ts_dout/ts_dout_en are registered: word present at ts_din on cycle t appears on ts_dout at t+1.
  - ts_dout holds its last value when ts_dout_en=0.
  - Back-to-back packets always have >= GAP_CYCLES idle cycles between them.
- Simultaneous events:
  - req deassertion after grant is ignored; the grant persists until completion or timeout.
  - port_en clearing mid-packet does not abort the packet; it takes effect at the next arbitration.
  - sync_err and len_err are never pulsed for the same packet.
- A rst assertion mid-packet immediately drops gnt and ts_dout_en; the partial packet is lost.

Test Plan:
- Single source 2 requests; packet of 47 words, first word 0x47001386 -> gnt=0100 for 47 en cycles, ts_dout equals ts_din delayed 1 cycle, 47 ts_dout_en cycles, then 1 idle cycle.
- All 4 sources request continuously -> grant order 0,1,2,3,0,... with each packet exactly 47 words and >=1 idle cycle between packets; port_en=1011 skips source 2.
- Granted source 1 never asserts en -> timeout_err pulses 16 cycles after gnt, gnt cleared, source 2 granted next.
- First word 0x48001386 -> sync_err pulse, ts_dout_en stays 0 for the whole burst, arbitration resumes after the gap.
- Source delivers 30 words then drops en -> 30 words forwarded, len_err pulse. Source delivers 50 words -> exactly 47 forwarded, len_err pulse.
- rst asserted on word 20 of a packet -> gnt=0 and ts_dout_en=0 immediately; after release, source 0 is granted first.
